// File: rtl/ps2_pkg.sv
// PS/2 Set-2 keyboard decode: shared byte codes,
// event bundle and decoder state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } ps2_evt_t;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    PAUSE
  } kbd_state_e;

  function automatic logic is_status(
    input logic [7:0] b
  );
    return (b == PS2_ACK)    ||
           (b == PS2_BAT_OK) ||
           (b == PS2_RESEND) ||
           (b == PS2_ERR0)   ||
           (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous FIFO with an extra pointer bit
// so full and empty are distinguishable.
module ps2_evt_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

  // A pop frees the head slot, so a full FIFO
  // can still accept a push on the same edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// Folds Set-2 prefixes into key events, turns
// status bytes into ticks, buffers events.
module ps2_kbd_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int PAUSE_LEN  = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_done_tick,
  input  logic [7:0]                    rx_data,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [9:0]                    evt_data,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic                          ack_tick,
  output logic                          bat_ok_tick,
  output logic                          resend_tick,
  output logic                          kbd_err_tick,
  output logic                          overflow,
  input  logic                          clr_ovf
);

  localparam int PCW = $clog2(PAUSE_LEN + 1);
  localparam logic [PCW-1:0] PLAST =
    PCW'(PAUSE_LEN - 1);

  kbd_state_e     state, state_n;
  logic [PCW-1:0] skip, skip_n;
  logic           push;
  ps2_evt_t       push_evt;
  logic           stat;
  logic           full;
  logic           empty;
  logic           drop;
  logic [9:0]     fifo_dout;

  // Status byte seen where it is not swallowed.
  always_comb begin
    stat = 1'b0;
    if (rx_done_tick && state != PAUSE)
      stat = is_status(rx_data);
  end

  // Prefix decoder: next state and push.
  always_comb begin
    state_n  = state;
    skip_n   = skip;
    push     = 1'b0;
    push_evt = '0;
    if (rx_done_tick) begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            rx_data == PS2_EXT:   state_n = EXT;
            rx_data == PS2_BRK:   state_n = BRK;
            rx_data == PS2_PAUSE: begin
              state_n = PAUSE;
              skip_n  = '0;
            end
            stat: state_n = IDLE;
            default: begin
              push     = 1'b1;
              push_evt = '{1'b0, 1'b0, rx_data};
            end
          endcase
        end
        EXT: begin
          unique case (1'b1)
            rx_data == PS2_BRK: state_n = EXT_BRK;
            rx_data == PS2_EXT: state_n = EXT;
            stat:               state_n = IDLE;
            default: begin
              push     = 1'b1;
              push_evt = '{1'b0, 1'b1, rx_data};
              state_n  = IDLE;
            end
          endcase
        end
        BRK: begin
          unique case (1'b1)
            stat:               state_n = IDLE;
            rx_data == PS2_EXT: state_n = EXT_BRK;
            default: begin
              push     = 1'b1;
              push_evt = '{1'b1, 1'b0, rx_data};
              state_n  = IDLE;
            end
          endcase
        end
        EXT_BRK: begin
          state_n = IDLE;
          if (!stat) begin
            push     = 1'b1;
            push_evt = '{1'b1, 1'b1, rx_data};
          end
        end
        PAUSE: begin
          skip_n = skip + 1'b1;
          if (skip == PLAST) begin
            push     = 1'b1;
            push_evt = '{1'b0, 1'b0, PS2_PAUSE};
            state_n  = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Decoder state and Pause skip counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      skip  <= '0;
    end else begin
      state <= state_n;
      skip  <= skip_n;
    end
  end

  // Status ticks, one cycle after the byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_tick     <= 1'b0;
      bat_ok_tick  <= 1'b0;
      resend_tick  <= 1'b0;
      kbd_err_tick <= 1'b0;
    end else begin
      ack_tick     <= stat && rx_data == PS2_ACK;
      bat_ok_tick  <= stat && rx_data == PS2_BAT_OK;
      resend_tick  <= stat && rx_data == PS2_RESEND;
      kbd_err_tick <= stat &&
        (rx_data == PS2_ERR0 || rx_data == PS2_ERR1);
    end
  end

  assign drop = push & full &
                ~(evt_valid & evt_ready);

  // Sticky overflow; a new drop beats clear.
  always_ff @(posedge clk) begin
    if (reset)        overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  ps2_evt_fifo #(
    .WIDTH (10),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (evt_ready),
    .din   (push_evt),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (evt_count)
  );

  assign evt_valid = ~empty;
  assign evt_data  = fifo_dout;

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Directed bench for ps2_kbd_decoder with
// hand-computed events, ticks and FIFO limits.
module tb_ps2_kbd_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       evt_valid;
  logic       evt_ready;
  logic [9:0] evt_data;
  logic [3:0] evt_count;
  logic       ack_tick;
  logic       bat_ok_tick;
  logic       resend_tick;
  logic       kbd_err_tick;
  logic       overflow;
  logic       clr_ovf;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ps2_kbd_decoder #(
    .FIFO_DEPTH (8),
    .PAUSE_LEN  (7)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_data     (evt_data),
    .evt_count    (evt_count),
    .ack_tick     (ack_tick),
    .bat_ok_tick  (bat_ok_tick),
    .resend_tick  (resend_tick),
    .kbd_err_tick (kbd_err_tick),
    .overflow     (overflow),
    .clr_ovf      (clr_ovf)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ticks();
    return {ack_tick, bat_ok_tick,
            resend_tick, kbd_err_tick};
  endfunction

  // One byte strobe, optionally with pop/clear;
  // returns at the negedge after the edge.
  task automatic drive(
    input logic [7:0] b,
    input logic       rdy,
    input logic       clr
  );
    @(negedge clk);
    rx_done_tick = 1'b1;
    rx_data      = b;
    evt_ready    = rdy;
    clr_ovf      = clr;
    @(negedge clk);
    rx_done_tick = 1'b0;
    evt_ready    = 1'b0;
    clr_ovf      = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    drive(b, 1'b0, 1'b0);
  endtask

  task automatic pop_chk(
    input string      tag,
    input logic [9:0] exp
  );
    chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
    chk({tag, "_data"}, 32'(evt_data), 32'(exp));
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [7:0] stat_b [5];
  logic [3:0] stat_t [5];
  logic [7:0] pause_b [8];

  initial begin
    stat_b  = '{8'hFA, 8'hAA, 8'hFE, 8'h00, 8'hFF};
    stat_t  = '{4'b1000, 4'b0100, 4'b0010,
                4'b0001, 4'b0001};
    pause_b = '{8'hE1, 8'h14, 8'h77, 8'hE1,
                8'hF0, 8'h14, 8'hF0, 8'h77};
    reset        = 1'b1;
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
    evt_ready    = 1'b0;
    clr_ovf      = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_count", 32'(evt_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_ticks", 32'(ticks()), 32'd0);

    send(8'h1C);
    chk("make_cnt", 32'(evt_count), 32'd1);
    pop_chk("make", 10'h01C);
    send(8'hF0);
    chk("brk_pend", 32'(evt_valid), 32'd0);
    send(8'h1C);
    pop_chk("brk", 10'h21C);

    send(8'hE0);
    send(8'h75);
    pop_chk("ext", 10'h175);
    send(8'hE0);
    send(8'hF0);
    chk("extbrk_pend", 32'(evt_count), 32'd0);
    send(8'h75);
    pop_chk("extbrk", 10'h375);
    send(8'hF0);
    send(8'hE0);
    send(8'h75);
    pop_chk("brkext", 10'h375);

    for (int i = 0; i < 8; i++) begin
      send(pause_b[i]);
      if (i < 7)
        chk($sformatf("pause_pend%0d", i),
            32'(evt_count), 32'd0);
    end
    chk("pause_cnt", 32'(evt_count), 32'd1);
    chk("pause_ticks", 32'(ticks()), 32'd0);
    pop_chk("pause", 10'h0E1);

    for (int i = 0; i < 5; i++) begin
      send(stat_b[i]);
      chk($sformatf("stat%0d_tick", i),
          32'(ticks()), 32'(stat_t[i]));
      chk($sformatf("stat%0d_cnt", i),
          32'(evt_count), 32'd0);
      @(negedge clk);
      chk($sformatf("stat%0d_off", i),
          32'(ticks()), 32'd0);
    end

    send(8'hE0);
    send(8'hFA);
    chk("e0fa_ack", 32'(ticks()), 32'b1000);
    send(8'h1C);
    pop_chk("e0fa_evt", 10'h01C);
    chk("e0fa_empty", 32'(evt_valid), 32'd0);

    for (int i = 0; i < 9; i++)
      send(8'h10 + 8'(i));
    chk("full_cnt", 32'(evt_count), 32'd8);
    chk("full_ovf", 32'(overflow), 32'd1);
    drive(8'h40, 1'b0, 1'b1);
    chk("set_wins", 32'(overflow), 32'd1);
    drive(8'h00, 1'b0, 1'b0);
    @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_cnt", 32'(evt_count), 32'd8);
    for (int i = 0; i < 8; i++)
      pop_chk($sformatf("drain%0d", i),
              10'(8'h10 + 8'(i)));
    chk("drain_empty", 32'(evt_valid), 32'd0);

    for (int i = 0; i < 8; i++)
      send(8'h20 + 8'(i));
    chk("refill_cnt", 32'(evt_count), 32'd8);
    drive(8'h30, 1'b1, 1'b0);
    chk("pp_cnt", 32'(evt_count), 32'd8);
    chk("pp_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i < 8; i++)
      pop_chk($sformatf("pp%0d", i),
              10'(8'h20 + 8'(i)));
    pop_chk("pp_last", 10'h030);
    chk("pp_empty", 32'(evt_count), 32'd0);
    @(negedge clk);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    chk("pop_empty", 32'(evt_count), 32'd0);

    send(8'h1C);
    send(8'hE0);
    do_reset();
    chk("mid_rst_cnt", 32'(evt_count), 32'd0);
    chk("mid_rst_vld", 32'(evt_valid), 32'd0);
    send(8'h75);
    pop_chk("mid_rst_evt", 10'h075);
    chk("mid_rst_end", 32'(evt_count), 32'd0);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
